// File: rtl/level_peak_window_pkg.sv
// Shared defaults and helpers for the level_peak_window block and its bus interface.
package level_peak_window_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_WINDOW = 1024;

  // Width of a counter that spans 0..n-1, never narrower than one bit.
  function automatic int count_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/level_peak_window_if.sv
// Sample-in / peak-out handshake bundle between the stream selector, the peak
// detector and the meter scaling stage.
interface level_peak_window_if
  import level_peak_window_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
);

  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] i_data;
  logic             o_valid;
  logic             o_ready;
  logic [width-2:0] o_data;
  logic             o_clip;

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, o_clip
  );

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, o_clip
  );

endinterface

// File: rtl/level_peak_window_abs_saturate.sv
// Saturating absolute value of a signed sample, plus a full-scale detector.
// The most negative code has no positive twin, so it is clamped to the largest
// positive magnitude; both rail codes are reported as full scale.
module abs_saturate #(
  parameter int width = 16
) (
  input  logic [width-1:0] data,
  output logic [width-2:0] mag,
  output logic             full_scale
);

  localparam logic [width-1:0] neg_rail = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] pos_rail = {1'b0, {(width-1){1'b1}}};

  // Magnitude: low bits of the two's-complement negation, clamped at the negative rail.
  always_comb begin
    mag = data[width-2:0];
    if (data[width-1]) begin
      if (data == neg_rail) begin
        mag = {(width-1){1'b1}};
      end else begin
        mag = ~data[width-2:0] + 1'b1;
      end
    end
  end

  // Full scale means sitting on either rail.
  always_comb begin
    full_scale = (data == neg_rail) || (data == pos_rail);
  end

endmodule

// File: rtl/level_peak_window.sv
// Windowed peak detector: tracks the largest saturated magnitude and any
// full-scale hit over each block of `window` accepted samples, then hands the
// result to the meter stage through a one-deep registered output.
module level_peak_window
  import level_peak_window_pkg::*;
#(
  parameter int width  = DEFAULT_WIDTH,
  parameter int window = DEFAULT_WINDOW
) (
  input  logic              clk,
  input  logic              reset,
  level_peak_window_if.slave bus
);

  localparam int cnt_w = count_width(window);
  localparam logic [cnt_w-1:0] last_count = cnt_w'(window - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } out_state_t;

  out_state_t       state;
  logic [width-2:0] peak;
  logic             clip_acc;
  logic [cnt_w-1:0] count;
  logic [width-2:0] out_data;
  logic             out_clip;

  logic [width-2:0] mag;
  logic             full_scale;
  logic [width-2:0] next_peak;
  logic             at_last;
  logic             ready;
  logic             accept;
  logic             closing;

  abs_saturate #(
    .width(width)
  ) u_abs (
    .data       (bus.i_data),
    .mag        (mag),
    .full_scale (full_scale)
  );

  // Only the sample that would close a window stalls, and only while the
  // previous result is still waiting and not being taken this cycle.
  always_comb begin
    next_peak = (mag > peak) ? mag : peak;
    at_last   = (count == last_count);
    ready     = !reset && !((state == FULL) && !bus.o_ready && at_last);
    accept    = bus.i_valid && ready;
    closing   = accept && at_last;
  end

  assign bus.i_ready = ready;
  assign bus.o_valid = (state == FULL);
  assign bus.o_data  = out_data;
  assign bus.o_clip  = out_clip;

  // Accumulate per window, publish on window close, and run the output hold FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      peak     <= '0;
      clip_acc <= 1'b0;
      count    <= '0;
      out_data <= '0;
      out_clip <= 1'b0;
    end else begin
      if (closing) begin
        out_data <= next_peak;
        out_clip <= clip_acc | full_scale;
        peak     <= '0;
        clip_acc <= 1'b0;
        count    <= '0;
        state    <= FULL;
      end else begin
        if (accept) begin
          peak     <= next_peak;
          clip_acc <= clip_acc | full_scale;
          count    <= count + 1'b1;
        end
        if ((state == FULL) && bus.o_ready) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_level_peak_window.sv
// Self-checking bench for level_peak_window (width=16, window=4) with a
// queue-based reference model of windows and pending results.
module tb_level_peak_window;

  localparam int WIDTH  = 16;
  localparam int WINDOW = 4;

  typedef struct {
    int peak;
    bit clip;
  } res_t;

  logic clk;
  logic reset;

  level_peak_window_if #(.width(WIDTH)) bus ();

  level_peak_window #(
    .width  (WIDTH),
    .window (WINDOW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int   win_q[$];
  res_t exp_q[$];
  int   acc_total = 0;

  logic        obs_ready, obs_valid, obs_clip;
  logic [14:0] obs_data;
  logic        m_ready, m_valid, m_clip;
  logic [14:0] m_data;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t window_result(input int s[$]);
    res_t r;
    int m;
    r.peak = 0;
    r.clip = 1'b0;
    foreach (s[i]) begin
      if (s[i] == -32768) m = 32767;
      else if (s[i] < 0) m = -s[i];
      else m = s[i];
      if (m > r.peak) r.peak = m;
      if (s[i] == -32768 || s[i] == 32767) r.clip = 1'b1;
    end
    return r;
  endfunction

  // One clock cycle: drive, observe pre-edge outputs, advance the model, clock.
  task automatic step(input logic v, input logic [15:0] d, input logic rdy);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.o_ready = rdy;
    m_valid = (exp_q.size() > 0);
    m_ready = !(m_valid && !rdy && win_q.size() == WINDOW - 1);
    m_data  = '0;
    m_clip  = 1'b0;
    if (m_valid) begin
      m_data = exp_q[0].peak[14:0];
      m_clip = exp_q[0].clip;
    end
    #1;
    obs_ready = bus.i_ready;
    obs_valid = bus.o_valid;
    obs_data  = bus.o_data;
    obs_clip  = bus.o_clip;
    if (m_valid && rdy) void'(exp_q.pop_front());
    if (v && m_ready) begin
      acc_total++;
      win_q.push_back(int'($signed(d)));
      if (win_q.size() == WINDOW) begin
        exp_q.push_back(window_result(win_q));
        win_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b1;
    bus.i_data  = 16'd5;
    bus.o_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.i_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_i_ready: got %b want 0", bus.i_ready); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_o_valid: got %b want 0", bus.o_valid); end
    n_checks++;
    if (bus.o_data !== 15'd0) begin n_fail++; $display("[TB] FAIL reset_o_data: got %0d want 0", bus.o_data); end
    n_checks++;
    if (bus.o_clip !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_o_clip: got %b want 0", bus.o_clip); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.i_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.i_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_i_ready: got %b want 1", bus.i_ready); end
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_o_valid: got %b want 0", bus.o_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int s[4] = '{100, -300, 200, 50};
    foreach (s[i]) begin
      step(1'b1, 16'(s[i]), 1'b1);
      n_checks++;
      if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ready[%0d]: got %b want 1", i, obs_ready); end
      n_checks++;
      if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_valid[%0d]: got %b want 0", i, obs_valid); end
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b want 1", obs_valid); end
    n_checks++;
    if (obs_data !== 15'd300) begin n_fail++; $display("[TB] FAIL basic_data: got %0d want 300", obs_data); end
    n_checks++;
    if (obs_clip !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_clip: got %b want 0", obs_clip); end
    n_checks++;
    if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_ready_after: got %b want 1", obs_ready); end
    step(1'b0, 16'd0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_pulse_end: got %b want 0", obs_valid); end
  endtask

  task automatic test_clip_window();
    int s[8] = '{-32768, 0, 0, 0, 1, 2, 3, 4};
    foreach (s[i]) begin
      step(1'b1, 16'(s[i]), 1'b1);
      if (i == 4) begin
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== 15'd32767 || obs_clip !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL clip_result: got v=%b d=%0d c=%b want v=1 d=32767 c=1", obs_valid, obs_data, obs_clip);
        end
      end
    end
    step(1'b0, 16'd0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_data !== 15'd4 || obs_clip !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fresh_window: got v=%b d=%0d c=%b want v=1 d=4 c=0", obs_valid, obs_data, obs_clip);
    end
    step(1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    int s[8] = '{5, -7, 3, 1, 10, 32767, -2, 0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 16'(s[i]), 1'b0);
      n_checks++;
      if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready[%0d]: got %b want 1", i, obs_ready); end
      if (i >= 4) begin
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== 15'd7 || obs_clip !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%0d c=%b want v=1 d=7 c=0", i, obs_valid, obs_data, obs_clip);
        end
      end
    end
    repeat (3) begin
      step(1'b1, 16'(s[7]), 1'b0);
      n_checks++;
      if (obs_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall: got %b want 0", obs_ready); end
      n_checks++;
      if (obs_valid !== 1'b1 || obs_data !== 15'd7) begin
        n_fail++;
        $display("[TB] FAIL bp_stall_hold: got v=%b d=%0d want v=1 d=7", obs_valid, obs_data);
      end
    end
    step(1'b1, 16'(s[7]), 1'b1);
    n_checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b1 || obs_data !== 15'd7) begin
      n_fail++;
      $display("[TB] FAIL bp_release: got r=%b v=%b d=%0d want r=1 v=1 d=7", obs_ready, obs_valid, obs_data);
    end
    step(1'b0, 16'd0, 1'b0);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_data !== 15'd32767 || obs_clip !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_result2: got v=%b d=%0d c=%b want v=1 d=32767 c=1", obs_valid, obs_data, obs_clip);
    end
    step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_drained: got %b want 0", obs_valid); end
  endtask

  task automatic test_back_to_back();
    int results = 0;
    for (int j = 0; j < 13; j++) begin
      logic [15:0] d;
      d = 16'($urandom);
      step(j < 12, d, 1'b1);
      n_checks++;
      if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_stall[%0d]: got %b want 1", j, obs_ready); end
      n_checks++;
      if (obs_valid !== (j == 4 || j == 8 || j == 12)) begin
        n_fail++;
        $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", j, obs_valid, (j == 4 || j == 8 || j == 12));
      end
      if (obs_valid === 1'b1) begin
        results++;
        n_checks++;
        if (obs_data !== m_data || obs_clip !== m_clip) begin
          n_fail++;
          $display("[TB] FAIL b2b_data[%0d]: got d=%0d c=%b want d=%0d c=%b", j, obs_data, obs_clip, m_data, m_clip);
        end
      end
    end
    n_checks++;
    if (results != 3) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d want 3", results); end
  endtask

  task automatic test_reset_midwindow();
    int pre[6]  = '{1000, 2000, 3000, 4000, -32768, 30000};
    int post[4] = '{11, -22, 33, -44};
    int k;
    foreach (pre[i]) step(1'b1, 16'(pre[i]), 1'b0);
    reset = 1'b1;
    bus.i_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.i_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_ready: got %b want 0", bus.i_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    win_q.delete();
    exp_q.delete();
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_drop: got %b want 0", bus.o_valid); end
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v, 16'(post[k]), 1'b1);
      n_checks++;
      if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_stale[%0d]: got %b want 0", c, obs_valid); end
      if (v) k++;
    end
    n_checks++;
    if (k != 4) begin n_fail++; $display("[TB] FAIL rst_mid_timeout: got %0d samples want 4", k); end
    step(1'b0, 16'd0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b1 || obs_data !== 15'd44 || obs_clip !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_result: got v=%b d=%0d c=%b want v=1 d=44 c=0", obs_valid, obs_data, obs_clip);
    end
    step(1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_random();
    logic        prev_hold = 1'b0;
    logic [14:0] prev_data = '0;
    logic        prev_clip = 1'b0;
    int          start = acc_total;
    int          cyc = 0;
    while (acc_total - start < 10000 && cyc < 40000) begin
      logic [15:0] d;
      int          r;
      logic        v, rdy;
      r = int'($urandom_range(0, 9));
      if (r == 0) d = 16'h8000;
      else if (r == 1) d = 16'h7fff;
      else begin
        d = 16'($urandom_range(0, 32767) >> $urandom_range(0, 14));
        if ($urandom_range(0, 1) == 1) d = 16'd0 - d;
      end
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      step(v, d, rdy);
      cyc++;
      n_checks++;
      if (obs_ready !== m_ready) begin n_fail++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", cyc, obs_ready, m_ready); end
      n_checks++;
      if (obs_valid !== m_valid) begin n_fail++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", cyc, obs_valid, m_valid); end
      if (m_valid) begin
        n_checks++;
        if (obs_data !== m_data || obs_clip !== m_clip) begin
          n_fail++;
          $display("[TB] FAIL rnd_result@%0d: got d=%0d c=%b want d=%0d c=%b", cyc, obs_data, obs_clip, m_data, m_clip);
        end
      end
      if (prev_hold) begin
        n_checks++;
        if (obs_valid !== 1'b1 || obs_data !== prev_data || obs_clip !== prev_clip) begin
          n_fail++;
          $display("[TB] FAIL rnd_stable@%0d: got v=%b d=%0d c=%b want v=1 d=%0d c=%b", cyc, obs_valid, obs_data, obs_clip, prev_data, prev_clip);
        end
      end
      prev_hold = (obs_valid === 1'b1) && !rdy;
      prev_data = obs_data;
      prev_clip = obs_clip;
    end
    n_checks++;
    if (acc_total - start < 10000) begin
      n_fail++;
      $display("[TB] FAIL rnd_budget: got %0d samples want 10000", acc_total - start);
    end
    repeat (3) step(1'b0, 16'd0, 1'b1);
    n_checks++;
    if (obs_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rnd_drain: got v=%b pending=%0d want v=0 pending=0", obs_valid, exp_q.size());
    end
  endtask

  // Test sequence.
  initial begin
    reset       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.o_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_clip_window();
    test_backpressure();
    test_back_to_back();
    test_reset_midwindow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #5_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/level_peak_window.md
# level_peak_window

Windowed peak detector for the level-meter datapath. It sits directly downstream of the two-input stream selector and consumes the selected signed PCM sample stream over a valid/ready handshake. For every block of `window` accepted samples it emits one saturated absolute-peak value plus a clip flag over a registered valid/ready output, which feeds the meter scaling/display stage.

## Interface
- `width`, 16: sample width; input is two's-complement signed.
- `window`, 1024: samples per measurement window; integer ≥ 2, need not be a power of two.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `i_valid` input 1: input sample valid.
- `i_ready` output 1: block accepts a sample this cycle.
- `i_data` input `width`: signed sample.
- `o_valid` output 1: peak result valid.
- `o_ready` input 1: consumer accepts the result.
- `o_data` output `width-1`: unsigned peak magnitude of the window.
- `o_clip` output 1: the window contained a full-scale sample.

## Operation
- Accept: a sample is taken on a cycle where `i_valid && i_ready`.
- Magnitude: `mag = |i_data|`, saturated. −2^(width−1) maps to 2^(width−1)−1. Result is `width-1` bits unsigned.
- Clip: a sample counts as clipped when `i_data` equals −2^(width−1) or +2^(width−1)−1.
- Internal state:
  - `peak` (`width-1` bits) = running maximum of `mag`.
  - `clip_acc` = OR of clip hits in the current window.
  - `count` (`$clog2(window)` bits), range 0..window−1.
- Per accepted sample with `count < window−1`:
  - `peak <= max(peak, mag)`, `clip_acc <= clip_acc | clip`, `count <= count+1`.
- Per accepted sample with `count == window−1` (window close):
  - `o_data <= max(peak, mag)`, `o_clip <= clip_acc | clip`, `o_valid <= 1`.
  - `peak`, `clip_acc` and `count` return to 0. The next window starts fresh with no carry-over.
- Output state machine, two states:
  - IDLE: `o_valid=0`.
  - FULL: `o_valid=1`, and `o_data`/`o_clip` are held stable.
  - IDLE→FULL on window close.
  - FULL→IDLE on `o_ready` without a simultaneous window close.
  - FULL→FULL (reloaded with the new result) on `o_ready` together with a window close.
- Backpressure: `i_ready = !reset && !(o_valid && !o_ready && count == window−1)`.
  - Accumulation continues while a result waits. Only the closing sample stalls.
  - A result is never overwritten before it is taken.
- Upstream contract: `i_data` is sampled only on handshake. Samples presented while `i_ready=0` are neither consumed nor counted.

## Timing
- Reset values: `o_valid=0`, `o_data=0`, `o_clip=0`, `peak=0`, `clip_acc=0`, `count=0`.
- `i_ready` is 0 while `reset` is high and 1 in the first cycle after release.
- Reset mid-window discards the partial window. Reset while FULL drops the pending result.
- Latency: `o_valid` rises on the clock edge that accepts the closing sample, so it is visible the cycle after that handshake.
- Throughput: one sample per cycle with no bubbles while `o_ready` is held high. This includes a window close coinciding with the previous result's acceptance.
- `i_ready` depends combinationally on `o_ready`. There is no combinational path from `i_valid`/`i_data` to any output.
- `o_valid` never deasserts without `o_ready`.

## Structure
- No shared package entries needed. State encoding and the clip constants are module-local parameters.
- One natural sub-module, `abs_saturate` (combinational):
  - `width`-bit signed in → `width-1`-bit magnitude out.
  - Plus a `full_scale` flag.
  - Reusable by the RMS path.

## Test plan
All scenarios use `width=16`, `window=4`.
- Reset release, then samples 100, −300, 200, 50 with `o_ready=1` → one `o_valid` pulse, `o_data=300`, `o_clip=0`; `i_ready` stays 1 throughout.
- Window of −32768, 0, 0, 0 → `o_data=32767`, `o_clip=1`. The next window of 1, 2, 3, 4 → `o_data=4`, `o_clip=0` (no carry-over).
- `o_ready=0`, two windows streamed:
  - Result 1 is held stable.
  - `i_ready` drops only when the 8th sample is presented.
  - Raise `o_ready` → result 1 is taken, and in the same cycle the 8th sample is accepted and result 2 is loaded.
- Continuous 12 samples with `i_valid=1`, `o_ready=1` → exactly 3 results, one cycle after samples 4, 8 and 12, with zero stall cycles.
- Random `i_valid` gaps plus `reset` asserted after 2 samples of a window → after release the counter restarts. The first result reflects only post-reset samples; no stale `o_valid`.
- Random `i_valid`/`o_ready` over 10k samples against a scoreboard:
  - Checks per-window max magnitude and clip flag.
  - Checks the handshake rules (`o_data` stable while `o_valid && !o_ready`).
